// File: rtl/issue_sb_pkg.sv
// Shared types and pointer helpers for the multi-port issue scoreboard.
// The entry struct is a macro so each scoreboard instance can size it from its own parameters.
`define ISSUE_SB_ENTRY_T(name, DW, EW, PW) \
  typedef struct packed { \
    logic          busy; \
    logic          issued; \
    logic          done; \
    logic          ex_valid; \
    logic [DW-1:0] data; \
    logic [EW-1:0] ex; \
    logic [PW-1:0] payload; \
  } name;

package issue_sb_pkg;

  localparam int unsigned DefDataWidth    = 64;
  localparam int unsigned DefExWidth      = 64;
  localparam int unsigned DefPayloadWidth = 96;

  `ISSUE_SB_ENTRY_T(sb_entry_t, DefDataWidth, DefExWidth, DefPayloadWidth)

  // Ring pointer advance; n is the ring size.
  function automatic int unsigned ptr_add(input int unsigned ptr, input int unsigned k,
                                          input int unsigned n);
    return (ptr + k) % n;
  endfunction

  // Length of the run of ones starting at bit 0, looking at the low n bits only.
  function automatic int unsigned popcount_prefix(input logic [31:0] v, input int unsigned n);
    int unsigned cnt;
    logic        run;
    cnt = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n) begin
        run = run & v[i];
        if (run) cnt++;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/issue_sb_wb_merge.sv
// Per-entry write-back merge: folds all write-back ports targeting EntryIdx into one update.
// Lowest port index wins the data and the exception info; the exception flag is the OR.
module issue_sb_wb_merge #(
  parameter int unsigned NrWbPorts = 4,
  parameter int unsigned TransIdW  = 3,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ExWidth   = 64,
  parameter int unsigned EntryIdx  = 0
) (
  input  logic [NrWbPorts-1:0]           wb_valid_i,
  input  logic [NrWbPorts*TransIdW-1:0]  wb_trans_id_i,
  input  logic [NrWbPorts*DataWidth-1:0] wb_data_i,
  input  logic [NrWbPorts-1:0]           wb_ex_valid_i,
  input  logic [NrWbPorts*ExWidth-1:0]   wb_ex_i,
  output logic                           hit_o,
  output logic [DataWidth-1:0]           data_o,
  output logic                           ex_valid_o,
  output logic [ExWidth-1:0]             ex_o
);

  logic [NrWbPorts-1:0] match;

  for (genvar p = 0; p < NrWbPorts; p++) begin : g_match
    assign match[p] = wb_valid_i[p] &&
                      (wb_trans_id_i[p*TransIdW +: TransIdW] == TransIdW'(EntryIdx));
  end

  // Walk from the highest port down so the lowest matching port overwrites last.
  always_comb begin
    hit_o      = 1'b0;
    data_o     = '0;
    ex_valid_o = 1'b0;
    ex_o       = '0;
    for (int p = NrWbPorts - 1; p >= 0; p--) begin
      if (match[p]) begin
        hit_o  = 1'b1;
        data_o = wb_data_i[p*DataWidth +: DataWidth];
        if (wb_ex_valid_i[p]) begin
          ex_valid_o = 1'b1;
          ex_o       = wb_ex_i[p*ExWidth +: ExWidth];
        end
      end
    end
  end

endmodule

// File: rtl/issue_scoreboard_mp.sv
// In-order issue, out-of-order write-back, in-order commit scoreboard with
// configurable depth, write-back/commit port counts and per-entry payload.
module issue_scoreboard_mp
  import issue_sb_pkg::*;
#(
  parameter int unsigned NrEntries     = 8,
  parameter int unsigned NrWbPorts     = 4,
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned PayloadWidth  = 96,
  parameter int unsigned ExWidth       = 64,
  parameter int unsigned TransIdW      = $clog2(NrEntries)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic                               flush_unissued_i,
  input  logic                               alloc_valid_i,
  input  logic [PayloadWidth-1:0]            alloc_payload_i,
  output logic                               alloc_ack_o,
  output logic                               sb_full_o,
  output logic                               issue_valid_o,
  output logic [PayloadWidth-1:0]            issue_payload_o,
  output logic [TransIdW-1:0]                issue_trans_id_o,
  input  logic                               issue_ack_i,
  input  logic [NrWbPorts-1:0]               wb_valid_i,
  input  logic [NrWbPorts*TransIdW-1:0]      wb_trans_id_i,
  input  logic [NrWbPorts*DataWidth-1:0]     wb_data_i,
  input  logic [NrWbPorts-1:0]               wb_ex_valid_i,
  input  logic [NrWbPorts*ExWidth-1:0]       wb_ex_i,
  output logic [NrCommitPorts-1:0]           commit_valid_o,
  output logic [NrCommitPorts*PayloadWidth-1:0] commit_payload_o,
  output logic [NrCommitPorts*DataWidth-1:0] commit_data_o,
  output logic [NrCommitPorts-1:0]           commit_ex_valid_o,
  output logic [NrCommitPorts*ExWidth-1:0]   commit_ex_o,
  input  logic [NrCommitPorts-1:0]           commit_ack_i
);

  localparam int unsigned CntW = TransIdW + 1;

  `ISSUE_SB_ENTRY_T(entry_t, DataWidth, ExWidth, PayloadWidth)

  entry_t              sb_q [NrEntries];
  entry_t              sb_d [NrEntries];
  logic [TransIdW-1:0] head_q, head_d, iss_q, iss_d, tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d;

  logic [NrEntries-1:0] wb_hit, wb_exv;
  logic [DataWidth-1:0] wb_data [NrEntries];
  logic [ExWidth-1:0]   wb_ex   [NrEntries];

  logic [TransIdW-1:0]  slot_idx [NrCommitPorts];
  logic                 chain;
  logic                 issue_fire;
  int unsigned          n_commit;
  logic [CntW-1:0]      n_unissued;
  logic [NrWbPorts-1:0] wb_legal;

  for (genvar e = 0; e < NrEntries; e++) begin : g_merge
    issue_sb_wb_merge #(
      .NrWbPorts (NrWbPorts),
      .TransIdW  (TransIdW),
      .DataWidth (DataWidth),
      .ExWidth   (ExWidth),
      .EntryIdx  (e)
    ) u_merge (
      .wb_valid_i    (wb_valid_i),
      .wb_trans_id_i (wb_trans_id_i),
      .wb_data_i     (wb_data_i),
      .wb_ex_valid_i (wb_ex_valid_i),
      .wb_ex_i       (wb_ex_i),
      .hit_o         (wb_hit[e]),
      .data_o        (wb_data[e]),
      .ex_valid_o    (wb_exv[e]),
      .ex_o          (wb_ex[e])
    );
  end

  assign sb_full_o        = (count_q == CntW'(NrEntries));
  assign alloc_ack_o      = alloc_valid_i & ~sb_full_o & ~flush_i & ~flush_unissued_i;
  assign issue_valid_o    = sb_q[iss_q].busy & ~sb_q[iss_q].issued & ~flush_i & ~flush_unissued_i;
  assign issue_payload_o  = issue_valid_o ? sb_q[iss_q].payload : '0;
  assign issue_trans_id_o = iss_q;
  assign issue_fire       = issue_valid_o & issue_ack_i;

  // Commit window: slot k shows entry head+k; data fields are zeroed on invalid slots.
  always_comb begin
    chain             = 1'b1;
    commit_valid_o    = '0;
    commit_payload_o  = '0;
    commit_data_o     = '0;
    commit_ex_valid_o = '0;
    commit_ex_o       = '0;
    for (int unsigned k = 0; k < NrCommitPorts; k++) begin
      slot_idx[k] = TransIdW'(ptr_add(32'(head_q), k, NrEntries));
      chain       = chain & sb_q[slot_idx[k]].done & (k < 32'(count_q));
      commit_valid_o[k] = chain;
      if (chain) begin
        commit_payload_o[k*PayloadWidth +: PayloadWidth] = sb_q[slot_idx[k]].payload;
        commit_data_o[k*DataWidth +: DataWidth]          = sb_q[slot_idx[k]].data;
        commit_ex_valid_o[k]                             = sb_q[slot_idx[k]].ex_valid;
        commit_ex_o[k*ExWidth +: ExWidth]                = sb_q[slot_idx[k]].ex;
      end
    end
  end

  assign n_commit = popcount_prefix(32'(commit_ack_i & commit_valid_o), NrCommitPorts);

  // Entries still waiting for issue; a full ring with iss==tail means all of them.
  always_comb begin
    n_unissued = '0;
    if (sb_q[iss_q].busy && !sb_q[iss_q].issued) begin
      n_unissued = (tail_q == iss_q) ? CntW'(NrEntries) : CntW'(TransIdW'(tail_q - iss_q));
    end
  end

  always_comb begin
    sb_d    = sb_q;
    head_d  = head_q;
    iss_d   = iss_q;
    tail_d  = tail_q;
    count_d = count_q + CntW'(alloc_ack_o) - CntW'(n_commit);

    for (int unsigned e = 0; e < NrEntries; e++) begin
      if (wb_hit[e] && sb_q[e].busy && sb_q[e].issued) begin
        sb_d[e].done     = 1'b1;
        sb_d[e].data     = wb_data[e];
        sb_d[e].ex_valid = wb_exv[e];
        sb_d[e].ex       = wb_ex[e];
      end
    end

    if (issue_fire) begin
      sb_d[iss_q].issued = 1'b1;
      iss_d              = iss_q + TransIdW'(1);
    end

    for (int unsigned k = 0; k < NrCommitPorts; k++) begin
      if (k < n_commit) begin
        sb_d[slot_idx[k]].busy     = 1'b0;
        sb_d[slot_idx[k]].issued   = 1'b0;
        sb_d[slot_idx[k]].done     = 1'b0;
        sb_d[slot_idx[k]].ex_valid = 1'b0;
      end
    end
    head_d = head_q + TransIdW'(n_commit);

    if (alloc_ack_o) begin
      sb_d[tail_q].payload  = alloc_payload_i;
      sb_d[tail_q].busy     = 1'b1;
      sb_d[tail_q].issued   = 1'b0;
      sb_d[tail_q].done     = 1'b0;
      sb_d[tail_q].ex_valid = 1'b0;
      tail_d                = tail_q + TransIdW'(1);
    end

    // Drop the unissued tail; issued entries stay and may still write back and commit.
    if (flush_unissued_i) begin
      for (int unsigned e = 0; e < NrEntries; e++) begin
        if (sb_q[e].busy && !sb_q[e].issued) sb_d[e].busy = 1'b0;
      end
      tail_d  = iss_q;
      count_d = count_q - n_unissued - CntW'(n_commit);
    end

    if (flush_i) begin
      for (int unsigned e = 0; e < NrEntries; e++) begin
        sb_d[e].busy     = 1'b0;
        sb_d[e].issued   = 1'b0;
        sb_d[e].done     = 1'b0;
        sb_d[e].ex_valid = 1'b0;
      end
      head_d  = '0;
      iss_d   = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned e = 0; e < NrEntries; e++) sb_q[e] <= '0;
      head_q  <= '0;
      iss_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      sb_q    <= sb_d;
      head_q  <= head_d;
      iss_q   <= iss_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NrWbPorts; p++) begin
      wb_legal[p] = sb_q[wb_trans_id_i[p*TransIdW +: TransIdW]].busy &&
                    sb_q[wb_trans_id_i[p*TransIdW +: TransIdW]].issued;
    end
  end

  wb_targets_issued : assert property (@(posedge clk_i) disable iff (!rst_ni)
    flush_i || ((wb_valid_i & ~wb_legal) == '0));

  commit_ack_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((commit_ack_i & ~commit_valid_o) == '0) && (((commit_ack_i >> 1) & ~commit_ack_i) == '0));

endmodule

// File: doc/issue_scoreboard_mp.md
Name: issue_scoreboard_mp

Overview:
Parametrised in-order-issue, out-of-order-writeback, in-order-commit scoreboard for the CVA6 issue path. It generalises the fixed single-issue scoreboard in three ways: configurable depth, configurable write-back and commit port counts, and a per-entry opaque payload. It adds selective flush of unissued entries and an exception-wins merge across write-back ports. It sits between decode (alloc) and issue-read-operands (issue), and feeds the commit stage.

Parameters:
NrEntries, 8, scoreboard depth; power of two, >=2
NrWbPorts, 4, write-back ports
NrCommitPorts, 2, commit ports; <= NrEntries
DataWidth, 64, write-back result width (XLEN)
PayloadWidth, 96, opaque decoded-instruction bits stored per entry
ExWidth, 64, exception cause+tval bits
TransIdW, $clog2(NrEntries), transaction ID width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  clear all entries
flush_unissued_i  in  1  drop entries allocated but not yet issued
alloc_valid_i  in  1  decoded instruction valid
alloc_payload_i  in  PayloadWidth  decoded instruction
alloc_ack_o  out  1  entry accepted this cycle
sb_full_o  out  1  all entries occupied
issue_valid_o  out  1  oldest unissued entry present
issue_payload_o  out  PayloadWidth  its payload
issue_trans_id_o  out  TransIdW  its index
issue_ack_i  in  1  entry dispatched to an FU
wb_valid_i  in  NrWbPorts  write-back strobe per port
wb_trans_id_i  in  NrWbPorts*TransIdW  target entry per port
wb_data_i  in  NrWbPorts*DataWidth  result per port
wb_ex_valid_i  in  NrWbPorts  exception flag per port
wb_ex_i  in  NrWbPorts*ExWidth  exception info per port
commit_valid_o  out  NrCommitPorts  slot k holds the (k)th-oldest entry, written back
commit_payload_o  out  NrCommitPorts*PayloadWidth  payloads
commit_data_o  out  NrCommitPorts*DataWidth  results
commit_ex_valid_o  out  NrCommitPorts  exception flags
commit_ex_o  out  NrCommitPorts*ExWidth  exception info
commit_ack_i  in  NrCommitPorts  retire slots; must be a prefix (ack[k] implies ack[k-1])

Behaviour:
- Per-entry state: busy, issued, done, ex_valid, data, ex, payload. Pointers head (commit), iss, tail (alloc), each TransIdW bits, wrapping modulo NrEntries. count is TransIdW+1 bits.
- Reset (async) and flush_i (sync): all flags 0, pointers 0, count 0. All outputs are 0 while in reset.
- Alloc: alloc_ack_o = alloc_valid_i & ~sb_full_o & ~flush_i & ~flush_unissued_i. On ack, write payload at tail, set busy, clear the other flags, tail++.
- sb_full_o = (count == NrEntries), computed from registered count. A same-cycle commit does not free space for an alloc in that cycle.
- Issue: issue_valid_o = busy[iss] & ~issued[iss] & ~flush_i & ~flush_unissued_i. On issue_ack_i, set issued[iss] and iss++. An alloc into the empty entry is visible at issue the next cycle; there is no bypass, so latency is 1.
- Write-back: for each port p with wb_valid_i[p], target entry e = wb_trans_id_i[p]. If busy & issued, set done and store data. If two ports hit the same entry, the lowest port index wins data; ex_valid is the OR of the hitting ports, and ex comes from the lowest index that has ex_valid. Write-back to an entry that is not issued is ignored (checked by assertion).
- Commit: slot k shows entry head+k (wrapped). commit_valid_o[k] = done[head+k] & commit_valid_o[k-1] & (k < count). Outputs are combinational from registers.
- On acks: pop popcount(commit_ack_i) entries (clear busy), head += n. An ack on an invalid slot is illegal (assertion).
- count_next = count + alloc - n_commit; all three updates may occur in one cycle.
- flush_unissued_i: clear busy on entries from iss to tail, set tail := iss, count := iss - head (mod). Issued entries are kept. If asserted in the same cycle as commits, commits still apply to head.
- flush_i overrides every other event in the same cycle.
- Entry index equals trans_id; it is reused only after commit.

Decomposition:
- Package issue_sb_pkg: sb_entry_t typedef (flags, data, ex, payload) built from parameters via a parameterised struct macro; helper functions ptr_add(ptr, k) and popcount_prefix().
- One sub-module: issue_sb_wb_merge. It is combinational and, per entry, reduces NrWbPorts matches into {hit, data, ex_valid, ex} with lowest-index priority. It is instantiated NrEntries times via generate.

Test Plan:
- Reset, then alloc 8 entries back-to-back (NrEntries=8) -> alloc_ack high for 8 cycles; sb_full_o=1 from cycle 8; 9th alloc not acked.
- Issue 3 entries, write back trans_id 2 then 0 then 1 -> commit_valid_o=00, then 01 (slot0=id0), then 11 (id0, id1 visible); ack 11 -> head=2, count=6.
- Ports 0 and 3 write trans_id 1 in the same cycle with data 0xA / 0xB, only port 3 with ex -> data=0xA, ex_valid=1, ex from port 3.
- Full SB with a commit of 1 and an alloc in the same cycle -> alloc not acked, count 8->7; next cycle alloc acked, count 8.
- 6 allocated, 2 issued, flush_unissued_i -> tail=2, count=2, issue_valid_o=0; later written-back entries 0 and 1 still commit.
- Wrap-around: 20 alloc/issue/wb/commit cycles with commit_ack=01 every cycle -> trans_ids cycle through 0..7, no lost or duplicated entries, count stays <=8; flush_i mid-stream -> all outputs 0 next cycle.
